// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-number width, hazard FSM
// states and forwarding-select codes used by hazard and forwarding units.
package pipeline_pkg;

   localparam int REGNO_SEL = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_M  = 2'd1,
      FWD_W  = 2'd2,
      FWD_WB = 2'd3
   } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
   import pipeline_pkg::*;

   logic [REGNO_SEL-1:0] src1_D;
   logic [REGNO_SEL-1:0] src2_D;
   logic                 src2_used_D;
   logic                 valid_D;
   logic [REGNO_SEL-1:0] dest_E;
   logic                 wrt_en_E;
   logic                 noop_E;
   logic                 mem_rd_E;
   logic                 br_taken_E;
   logic                 mem_req_M;
   logic                 mem_ack_M;
   logic                 stall_F;
   logic                 stall_D;
   logic                 bubble_E;
   logic                 flush_D;
   logic                 freeze;
   logic [1:0]           state_o;

   modport master (
      output src1_D, src2_D, src2_used_D, valid_D,
      output dest_E, wrt_en_E, noop_E, mem_rd_E, br_taken_E,
      output mem_req_M, mem_ack_M,
      input  stall_F, stall_D, bubble_E, flush_D, freeze, state_o
   );

   modport slave (
      input  src1_D, src2_D, src2_used_D, valid_D,
      input  dest_E, wrt_en_E, noop_E, mem_rd_E, br_taken_E,
      input  mem_req_M, mem_ack_M,
      output stall_F, stall_D, bubble_E, flush_D, freeze, state_o
   );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// hazard_cmp: D-vs-E register dependency compare and load-use detect.
// dep_hit is kept separate so multi-cycle ops can reuse it later.
module hazard_cmp
   import pipeline_pkg::*;
(
   input  logic [REGNO_SEL-1:0] src1_D,
   input  logic [REGNO_SEL-1:0] src2_D,
   input  logic                 src2_used_D,
   input  logic                 valid_D,
   input  logic [REGNO_SEL-1:0] dest_E,
   input  logic                 wrt_en_E,
   input  logic                 noop_E,
   input  logic                 mem_rd_E,
   output logic                 dep_hit,
   output logic                 load_use
);

   logic src_match;

   // a real E-stage writer whose dest feeds a real D-stage read
   always_comb begin
      src_match = (src1_D == dest_E) |
                  (src2_used_D & (src2_D == dest_E));
      dep_hit   = wrt_en_E & ~noop_E & valid_D & src_match;
      load_use  = dep_hit & mem_rd_E;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / bubble / flush / freeze sequencing.
// HAZARD_PERF_EN adds saturating stall/flush/memwait counters.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)(
   input  logic clk,
   input  logic reset_n,
   hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
`endif
);

   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

   hz_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic dep_hit;
   logic load_use;
   logic mem_busy;
   logic stall_f, stall_d, bubble_e, flush_d, freeze;
   logic lu_bubble;

   hazard_cmp u_cmp (
      .src1_D      (hz.src1_D),
      .src2_D      (hz.src2_D),
      .src2_used_D (hz.src2_used_D),
      .valid_D     (hz.valid_D),
      .dest_E      (hz.dest_E),
      .wrt_en_E    (hz.wrt_en_E),
      .noop_E      (hz.noop_E),
      .mem_rd_E    (hz.mem_rd_E),
      .dep_hit     (dep_hit),
      .load_use    (load_use)
   );

   assign mem_busy = hz.mem_req_M & ~hz.mem_ack_M;

   // next state, flush counter and pipeline controls; all 0 in reset
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      bubble_e  = 1'b0;
      flush_d   = 1'b0;
      freeze    = 1'b0;
      lu_bubble = 1'b0;
      if (reset_n) begin
         case (state_q)
            ST_RUN: begin
               if (mem_busy) begin
                  freeze  = 1'b1;
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  state_d = ST_MEM_WAIT;
               end else if (hz.br_taken_E) begin
                  flush_d  = 1'b1;
                  bubble_e = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = ST_FLUSH;
                     cnt_d   = CNT_INIT;
                  end
               end else if (load_use) begin
                  stall_f   = 1'b1;
                  stall_d   = 1'b1;
                  bubble_e  = 1'b1;
                  lu_bubble = 1'b1;
               end
            end
            ST_FLUSH: begin
               flush_d = 1'b1;
               if (mem_busy) begin
                  freeze  = 1'b1;
                  stall_f = 1'b1;
                  stall_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CW'(1)) state_d = ST_RUN;
               end
            end
            ST_MEM_WAIT: begin
               freeze  = ~hz.mem_ack_M;
               stall_f = ~hz.mem_ack_M;
               stall_d = ~hz.mem_ack_M;
               if (hz.mem_ack_M) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // FSM state and flush countdown
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.stall_F  = stall_f;
   assign hz.stall_D  = stall_d;
   assign hz.bubble_E = bubble_e;
   assign hz.flush_D  = flush_d;
   assign hz.freeze   = freeze;
   assign hz.state_o  = reset_n ? state_q : 2'd0;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

   // saturating event counters
   always_comb begin
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      memwait_cnt_d = memwait_cnt_q;
      if (lu_bubble && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_d && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + 1'b1;
      if (freeze && memwait_cnt_q != '1)
         memwait_cnt_d = memwait_cnt_q + 1'b1;
   end

   // counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         memwait_cnt_q <= '0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         memwait_cnt_q <= memwait_cnt_d;
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign memwait_cnt = memwait_cnt_q;
`endif

   logic unused_ok;
   assign unused_ok = dep_hit;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (FLUSH_CYCLES=2).
// Expected control vectors are queued per step and popped at the sample point.
module tb_hazard_ctrl;
   import pipeline_pkg::*;

   // {stall_F, stall_D, bubble_E, flush_D, freeze, state[1:0]}
   localparam logic [6:0] E_IDLE   = 7'b00000_00;
   localparam logic [6:0] E_LU     = 7'b11100_00;
   localparam logic [6:0] E_BR     = 7'b00110_00;
   localparam logic [6:0] E_FL     = 7'b00010_01;
   localparam logic [6:0] E_FRZ_R  = 7'b11001_00;
   localparam logic [6:0] E_FRZ_W  = 7'b11001_10;
   localparam logic [6:0] E_ACK_W  = 7'b00000_10;
   localparam logic [6:0] E_FL_FRZ = 7'b11011_01;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

   hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .memwait_cnt (memwait_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [6:0] exp_q[$];
   string      tag_q[$];

   function automatic logic [6:0] obs();
      return {hz.stall_F, hz.stall_D, hz.bubble_E,
              hz.flush_D, hz.freeze, hz.state_o};
   endfunction

   task automatic expect_out(input logic [6:0] e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic check_out();
      logic [6:0] e;
      logic [6:0] o;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = obs();
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: got %b want %b", t, o, e);
      end
   endtask

   task automatic cyc(input logic [6:0] e, input string t);
      expect_out(e, t);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string t,
                            input logic [15:0] got,
                            input logic [15:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", t, got, want);
      end
   endtask

   task automatic idle();
      hz.src1_D      = '0;
      hz.src2_D      = '0;
      hz.src2_used_D = 1'b0;
      hz.valid_D     = 1'b0;
      hz.dest_E      = '0;
      hz.wrt_en_E    = 1'b0;
      hz.noop_E      = 1'b0;
      hz.mem_rd_E    = 1'b0;
      hz.br_taken_E  = 1'b0;
      hz.mem_req_M   = 1'b0;
      hz.mem_ack_M   = 1'b0;
   endtask

   task automatic set_lu();
      hz.dest_E   = 4'd5;
      hz.mem_rd_E = 1'b1;
      hz.wrt_en_E = 1'b1;
      hz.src1_D   = 4'd5;
      hz.valid_D  = 1'b1;
   endtask

   initial begin
      idle();
      set_lu();
      cyc(E_IDLE, "reset_masks_lu");
`ifdef HAZARD_PERF_EN
      check_cnt("rst_stall_cnt", stall_cnt, 16'd0);
`endif
      reset_n = 1'b1;
      idle();
      cyc(E_IDLE, "idle");

      // load-use on src1: one bubble, then the load has moved on
      set_lu();
      cyc(E_LU, "t1_lu");
      hz.noop_E = 1'b1;
      cyc(E_IDLE, "t1_after");
`ifdef HAZARD_PERF_EN
      check_cnt("t1_stall_cnt", stall_cnt, 16'd1);
`endif
      idle();

      // src2 only counts when it is read
      set_lu();
      hz.src1_D = 4'd3;
      hz.src2_D = 4'd5;
      cyc(E_IDLE, "t2_src2_unused");
      hz.src2_used_D = 1'b1;
      cyc(E_LU, "t2_src2_used");
      hz.valid_D = 1'b0;
      cyc(E_IDLE, "t2_invalid_D");
      hz.valid_D = 1'b1;
      hz.noop_E  = 1'b1;
      cyc(E_IDLE, "t2_noop_E");
      idle();

      // taken branch: two flush cycles, bubble in the first only
      hz.br_taken_E = 1'b1;
      cyc(E_BR, "t3_br");
      hz.br_taken_E = 1'b0;
      cyc(E_FL, "t3_flush2");
      cyc(E_IDLE, "t3_run");
`ifdef HAZARD_PERF_EN
      check_cnt("t3_flush_cnt", flush_cnt, 16'd2);
`endif

      // memory wait: 3 frozen cycles, unfrozen ack cycle
      hz.mem_req_M = 1'b1;
      cyc(E_FRZ_R, "t4_frz1");
      cyc(E_FRZ_W, "t4_frz2");
      cyc(E_FRZ_W, "t4_frz3");
      hz.mem_ack_M = 1'b1;
      cyc(E_ACK_W, "t4_ack");
      hz.mem_req_M = 1'b0;
      hz.mem_ack_M = 1'b0;
      cyc(E_IDLE, "t4_run");
`ifdef HAZARD_PERF_EN
      check_cnt("t4_memwait_cnt", memwait_cnt, 16'd3);
`endif

      // single-cycle memory never leaves RUN
      hz.mem_req_M = 1'b1;
      hz.mem_ack_M = 1'b1;
      cyc(E_IDLE, "t4_1cyc");
      cyc(E_IDLE, "t4_1cyc_stay");
      idle();

      // branch beats load-use; load-use ignored while flushing
      set_lu();
      hz.br_taken_E = 1'b1;
      cyc(E_BR, "t5_br_wins");
      hz.br_taken_E = 1'b0;
      cyc(E_FL, "t5_lu_ignored");
      cyc(E_LU, "t5_lu_in_run");
      idle();

      // memory wait during flush holds the countdown
      hz.br_taken_E = 1'b1;
      cyc(E_BR, "t5b_br");
      hz.br_taken_E = 1'b0;
      hz.mem_req_M  = 1'b1;
      cyc(E_FL_FRZ, "t5b_frz1");
      cyc(E_FL_FRZ, "t5b_frz2");
      hz.mem_ack_M = 1'b1;
      cyc(E_FL, "t5b_resume");
      idle();
      cyc(E_IDLE, "t5b_run");

      // async reset in the middle of a flush
      hz.br_taken_E = 1'b1;
      cyc(E_BR, "t6_br");
      hz.br_taken_E = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      expect_out(E_IDLE, "t6_reset_async");
      check_out();
`ifdef HAZARD_PERF_EN
      check_cnt("t6_stall_cnt", stall_cnt, 16'd0);
      check_cnt("t6_flush_cnt", flush_cnt, 16'd0);
      check_cnt("t6_memwait_cnt", memwait_cnt, 16'd0);
`endif
      @(posedge clk);
      #1 reset_n = 1'b1;
      cyc(E_IDLE, "t6_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
